// File: rtl/score_bcd_packer.sv
// Packs a 16-bit user ID and a saturated binary score into the 32-bit display word.
// The score is converted to packed BCD by a sequential shift-add-3 (double-dabble) engine;
// the output register is written once per conversion so the display never sees partial digits.
module score_bcd_packer #(
    parameter int unsigned SCORE_BITS   = 14,
    parameter int unsigned SCORE_DIGITS = 4,
    parameter int unsigned SCORE_MAX    = 9999
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_i,
    input  logic [15:0]           user_id_i,
    input  logic [SCORE_BITS-1:0] score_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [31:0]           user_id_score_o
);

    localparam int unsigned BcdW = 4 * SCORE_DIGITS;
    localparam int unsigned CntW = $clog2(SCORE_BITS + 1);

    localparam logic [SCORE_BITS-1:0] ScoreMax = SCORE_BITS'(SCORE_MAX);
    localparam logic [CntW-1:0]       CntInit  = CntW'(SCORE_BITS);
    localparam logic [CntW-1:0]       CntOne   = CntW'(1);

    // StWrap is the single cycle after the last shift, used to publish the result.
    typedef enum logic [1:0] {
        StIdle,
        StConv,
        StWrap
    } state_e;

    state_e                state_q, state_d;
    logic [15:0]           id_q, id_d;
    logic [SCORE_BITS-1:0] bin_q, bin_d;
    logic [BcdW-1:0]       bcd_q, bcd_d;
    logic [BcdW-1:0]       bcd_adj;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [31:0]           out_q, out_d;
    logic                  done_q, done_d;

    // Add-3 correction: every digit >= 5 is bumped so the following shift carries correctly.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < int'(SCORE_DIGITS); i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // Next-state logic: capture in idle, shift while converting, publish on wrap.
    always_comb begin
        state_d = state_q;
        id_d    = id_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (load_i) begin
                    id_d    = user_id_i;
                    bin_d   = (score_i > ScoreMax) ? ScoreMax : score_i;
                    bcd_d   = '0;
                    cnt_d   = CntInit;
                    state_d = StConv;
                end
            end
            StConv: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q - CntOne;
                if (cnt_q == CntOne) begin
                    state_d = StWrap;
                end
            end
            StWrap: begin
                // Load requests here are dropped; only idle accepts work.
                out_d   = 32'({id_q, bcd_q});
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion and clears the output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            id_q    <= '0;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
            out_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            id_q    <= id_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            done_q  <= done_d;
        end
    end

    assign busy_o          = (state_q == StConv);
    assign done_o          = done_q;
    assign user_id_score_o = out_q;

endmodule

// File: tb/tb_score_bcd_packer.sv
// Randomised self-checking bench for score_bcd_packer against an arithmetic reference model.
module tb_score_bcd_packer;

    logic        clk;
    logic        rst_n;
    logic        load_i;
    logic [15:0] user_id_i;
    logic [13:0] score_i;
    logic        busy_o;
    logic        done_o;
    logic [31:0] user_id_score_o;

    int unsigned n_checks;
    int unsigned n_fail;
    logic [31:0] exp_out;

    score_bcd_packer dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .load_i          (load_i),
        .user_id_i       (user_id_i),
        .score_i         (score_i),
        .busy_o          (busy_o),
        .done_o          (done_o),
        .user_id_score_o (user_id_score_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: ID passes through, score saturates then is written as decimal digits.
    function automatic logic [31:0] model(input logic [15:0] id, input int unsigned s);
        int unsigned v;
        logic [15:0] b;
        v = (s > 9999) ? 9999 : s;
        b = '0;
        for (int d = 0; d < 4; d++) begin
            b[4*d +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return {id, b};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts a conversion from idle; returns at the sample where done is seen.
    task automatic run_conv(input logic [15:0] id, input logic [13:0] sc, input bit noise);
        int lat;
        int busy_cnt;
        bit got;
        load_i    = 1'b1;
        user_id_i = id;
        score_i   = sc;
        tick();
        load_i   = 1'b0;
        busy_cnt = 0;
        got      = 1'b0;
        lat      = 0;
        for (int i = 1; i <= 40; i++) begin
            if (busy_o) busy_cnt++;
            if (noise) begin
                load_i    = 1'($urandom_range(0, 1));
                user_id_i = 16'($urandom);
                score_i   = 14'($urandom);
            end
            tick();
            lat = i;
            if (done_o) begin
                got = 1'b1;
                break;
            end
            check("hold", user_id_score_o, exp_out);
        end
        load_i = 1'b0;
        check("latency", 32'(lat), 32'd15);
        check("busy_len", 32'(busy_cnt), 32'd14);
        exp_out = model(id, 32'(sc));
        check("result", user_id_score_o, exp_out);
    endtask

    initial begin
        int dones;
        n_checks  = 0;
        n_fail    = 0;
        exp_out   = '0;
        rst_n     = 1'b0;
        load_i    = 1'b0;
        user_id_i = '0;
        score_i   = '0;
        repeat (3) tick();
        check("rst_out", user_id_score_o, 32'h0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed cases, including zero, maximum and saturation.
        run_conv(16'hA5C3, 14'd1234, 1'b0);
        check("t1_word", user_id_score_o, 32'hA5C3_1234);
        tick();
        check("done_pulse", 32'(done_o), 32'd0);
        run_conv(16'h0000, 14'd0, 1'b0);
        check("t2_zero", user_id_score_o, 32'h0000_0000);
        run_conv(16'hFEDC, 14'd9999, 1'b0);
        check("t2_max", user_id_score_o, 32'hFEDC_9999);
        run_conv(16'h0001, 14'd16383, 1'b0);
        check("t3_sat", user_id_score_o, 32'h0001_9999);
        tick();
        check("done_pulse", 32'(done_o), 32'd0);

        // Load during busy is dropped: exactly one done for the first request.
        load_i    = 1'b1;
        user_id_i = 16'h1111;
        score_i   = 14'd42;
        tick();
        load_i = 1'b0;
        repeat (4) tick();
        load_i    = 1'b1;
        user_id_i = 16'h2222;
        score_i   = 14'd77;
        tick();
        load_i = 1'b0;
        dones  = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (done_o) dones++;
        end
        check("t4_dones", 32'(dones), 32'd1);
        exp_out = 32'h1111_0042;
        check("t4_word", user_id_score_o, exp_out);

        // Back-to-back: the second load sits in the done cycle.
        run_conv(16'hBEEF, 14'd321, 1'b0);
        run_conv(16'hBEEF, 14'd500, 1'b0);
        check("t5_word", user_id_score_o, 32'hBEEF_0500);
        tick();
        check("done_pulse", 32'(done_o), 32'd0);

        // Randomised conversions with input noise during conversion and random gaps.
        for (int n = 0; n < 24; n++) begin
            int gap;
            logic [15:0] rid;
            logic [13:0] rsc;
            rid = 16'($urandom);
            rsc = (n % 3 == 0) ? 14'($urandom_range(9990, 16383)) : 14'($urandom_range(0, 9999));
            run_conv(rid, rsc, 1'b1);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                tick();
                check("idle_hold", user_id_score_o, exp_out);
                check("idle_done", 32'(done_o), 32'd0);
            end
        end

        // Reset mid-conversion clears everything at once and produces no done afterwards.
        tick();
        load_i    = 1'b1;
        user_id_i = 16'h7777;
        score_i   = 14'd888;
        tick();
        load_i = 1'b0;
        repeat (5) tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_out", user_id_score_o, 32'h0);
        check("t6_busy", 32'(busy_o), 32'd0);
        check("t6_done", 32'(done_o), 32'd0);
        tick();
        rst_n   = 1'b1;
        exp_out = '0;
        dones   = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done_o) dones++;
        end
        check("t6_nodone", 32'(dones), 32'd0);
        check("t6_hold", user_id_score_o, exp_out);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
